fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller. It drives one shared multiplier/accumulator through NTAPS taps for each accepted input sample, using a shift-register delay line and a programmable coefficient bank. Each result is saturated to the output format. The block sits between an upstream sample source (valid/ready) and a downstream consumer (valid pulse). It replaces the parallel 4-multiplier FIR where area matters more than throughput.

Parameters:
NB_INPUT, 8, input sample width, signed S(8,7)
NBF_INPUT, 7, input fractional bits
NB_COEFF, 8, coefficient width, signed S(8,7)
NBF_COEFF, 7, coefficient fractional bits
NB_OUTPUT, 8, output width, signed S(8,7)
NBF_OUTPUT, 7, output fractional bits
NTAPS, 4, number of taps (>=2)
NB_ADDR, 2, coefficient address width, must satisfy 2**NB_ADDR >= NTAPS

Ports:
clk  input  1  system clock
i_srst  input  1  reset; synchronous, active-high
i_en  input  1  global enable; 0 freezes all state
i_valid  input  1  input sample valid
i_is_data  input  NB_INPUT  input sample, signed
o_ready  output  1  block can accept a sample this cycle
o_valid  output  1  output sample valid, one-cycle pulse
o_os_data  output  NB_OUTPUT  filtered, saturated output, signed
i_coef_we  input  1  coefficient write strobe
i_coef_addr  input  NB_ADDR  coefficient index (tap k)
i_coef_data  input  NB_COEFF  coefficient value, signed

Behaviour:
- Reset: synchronous on i_srst=1 at posedge clk, and it overrides everything, i_en included.
  - Reset state: IDLE, tap counter 0, accumulator 0, delay line all 0, o_valid 0, o_os_data 0.
  - Coefficients reset to defaults c[0..3] = 0x80, 0x40, 0xE0, 0x10 (-1, 1/2, -1/4, 1/8). For NTAPS > 4, taps 4+ reset to 0.
  - A reset during MAC aborts the computation; no o_valid follows.
- i_en=0: state, counter, accumulator, delay line, coefficients, o_valid and o_os_data all hold. o_ready=0.
- FSM has two states, IDLE and MAC. All transitions below require i_en=1.
  - o_ready = (state==IDLE) & i_en.
- IDLE, with i_valid & o_ready at edge T (accept):
  - Delay line shifts: x[0] <= i_is_data, x[k] <= x[k-1].
  - Accumulator <= 0, counter <= 0, state -> MAC.
  - i_valid while not ready is ignored; the sample is not queued.
- MAC, one tap per edge:
  - acc <= acc + c[cnt]*x[cnt], where the product is full-precision signed, NB_INPUT+NB_COEFF bits.
  - The counter increments each edge.
  - On the edge with cnt==NTAPS-1: o_os_data <= sat(acc + last product), o_valid <= 1, state -> IDLE.
- o_valid is high for exactly one enabled cycle and is cleared on the next enabled edge. o_os_data holds its value between results.
- Latency and throughput:
  - o_valid is high in the cycle after edge T+NTAPS, i.e. NTAPS enabled cycles after the accept edge.
  - o_ready is high in that same cycle, so back-to-back samples are accepted every NTAPS+1 cycles.
- Accumulator width NB_ADD = NB_INPUT+NB_COEFF+2 (18 bits). Fractional bits NBF_ADD = NBF_INPUT+NBF_COEFF = 14.
- Saturation, with NB_SAT = (NB_ADD-NBF_ADD)-(NB_OUTPUT-NBF_OUTPUT) = 3:
  - If the top NB_SAT+1 bits of the sum are all 0 or all 1, the output is the truncated slice sum[NB_ADD-NB_SAT-1 -: NB_OUTPUT] (bits [14:7]).
  - Otherwise the output is 0x80 if the sum is negative, 0x7F if positive.
  - No rounding.
- Coefficient writes:
  - Applied at an edge only when i_coef_we & i_en & state==IDLE & i_coef_addr<NTAPS.
  - Writes while in MAC, or to out-of-range addresses, are dropped silently.
  - A write in the same cycle as a sample accept is applied, and the new value is used by that computation.

Test Plan:
- Impulse: reset, then accept 0x40 followed by four 0x00 samples -> o_os_data = 0xC0, 0x20, 0xF0, 0x08, 0x00.
- Step and saturation: accept five samples of 0x80 -> outputs 0x7F (saturated +1.0), 0x40, 0x60, 0x50, 0x50.
- Timing: i_valid held high continuously -> o_ready high 1 cycle in every 5; o_valid exactly 4 cycles after each accept edge; single-cycle pulses.
- Coefficient write:
  - In IDLE, write addr0=0x40, then accept 0x40 from a zeroed delay line -> 0x20.
  - Write addr1=0x7F during MAC -> ignored; c[1] stays 0x40 (check with an impulse).
  - Write to addr >= NTAPS when NTAPS < 2**NB_ADDR -> ignored.
- Stall: drop i_en for 3 cycles mid-MAC -> no state change; o_valid is delayed by exactly 3 cycles and the value matches the unstalled run. A stall while o_valid=1 holds the pulse.
- Reset mid-MAC: assert i_srst at tap 2 -> no o_valid; o_ready=1 the next cycle; coefficients are back to their defaults; the next impulse 0x40 gives 0xC0.

Source files
------------

// File: rtl/fir_mac_if.sv
// Sample stream and coefficient-write bundle for the time-multiplexed FIR.
// The slave side is the filter; the master side is the sample source/host.
interface fir_mac_if #(
   parameter int NB_INPUT  = 8,
   parameter int NB_COEFF  = 8,
   parameter int NB_OUTPUT = 8,
   parameter int NB_ADDR   = 2
);
   logic                 i_valid;
   logic [NB_INPUT-1:0]  i_is_data;
   logic                 o_ready;
   logic                 o_valid;
   logic [NB_OUTPUT-1:0] o_os_data;
   logic                 i_coef_we;
   logic [NB_ADDR-1:0]   i_coef_addr;
   logic [NB_COEFF-1:0]  i_coef_data;

   modport slave (
      input  i_valid, i_is_data, i_coef_we, i_coef_addr, i_coef_data,
      output o_ready, o_valid, o_os_data
   );

   modport master (
      output i_valid, i_is_data, i_coef_we, i_coef_addr, i_coef_data,
      input  o_ready, o_valid, o_os_data
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate walks NTAPS taps per
// accepted sample, then saturates the sum into the output format.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes allowed
// MAC   | one tap per enabled edge, result and pulse on the last tap
module fir_mac_sequencer #(
   parameter int NB_INPUT   = 8,
   parameter int NBF_INPUT  = 7,
   parameter int NB_COEFF   = 8,
   parameter int NBF_COEFF  = 7,
   parameter int NB_OUTPUT  = 8,
   parameter int NBF_OUTPUT = 7,
   parameter int NTAPS      = 4,
   parameter int NB_ADDR    = 2
) (
   input  logic     clk,
   input  logic     i_srst,
   input  logic     i_en,
   fir_mac_if.slave bus
);

   localparam int NB_PROD = NB_INPUT + NB_COEFF;
   localparam int NB_ADD  = NB_PROD + 2;
   localparam int NBF_ADD = NBF_INPUT + NBF_COEFF;
   localparam int NB_SAT  = (NB_ADD - NBF_ADD) - (NB_OUTPUT - NBF_OUTPUT);
   localparam int NSLOT   = 1 << NB_ADDR;

   localparam logic [NB_ADDR-1:0]   LAST_TAP = NB_ADDR'(NTAPS - 1);
   localparam logic [NB_ADDR:0]     NTAPS_W  = (NB_ADDR + 1)'(NTAPS);
   localparam logic [NB_OUTPUT-1:0] OUT_MIN  = {1'b1, {(NB_OUTPUT-1){1'b0}}};
   localparam logic [NB_OUTPUT-1:0] OUT_MAX  = {1'b0, {(NB_OUTPUT-1){1'b1}}};

   typedef enum logic {IDLE, MAC} state_t;

   state_t                      state_q, state_d;
   logic [NB_ADDR-1:0]          cnt_q;
   logic signed [NB_ADD-1:0]    acc_q;
   logic [NB_INPUT-1:0]         x_q    [NSLOT];
   logic [NB_COEFF-1:0]         coef_q [NSLOT];
   logic [NB_OUTPUT-1:0]        out_q;
   logic                        valid_q;

   logic                        ready;
   logic                        accept;
   logic                        last_tap;
   logic                        coef_wr;
   logic [NB_COEFF-1:0]         coef_sel;
   logic [NB_INPUT-1:0]         x_sel;
   logic signed [NB_PROD-1:0]   coef_ext, x_ext, prod;
   logic signed [NB_ADD-1:0]    sum;
   logic [NB_SAT:0]             sum_top;
   logic [NB_OUTPUT-1:0]        sat_val;

   // Defaults -1, 1/2, -1/4, 1/8 scaled to the coefficient's fractional bits.
   function automatic logic [NB_COEFF-1:0] coef_default(input int k);
      case (k)
         0:       return NB_COEFF'(-(1 << NBF_COEFF));
         1:       return NB_COEFF'(1 << (NBF_COEFF - 1));
         2:       return NB_COEFF'(-(1 << (NBF_COEFF - 2)));
         3:       return NB_COEFF'(1 << (NBF_COEFF - 3));
         default: return '0;
      endcase
   endfunction

   // state register
   always_ff @(posedge clk) begin
      if (i_srst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      if (i_en) begin
         case (state_q)
            IDLE:    if (accept)   state_d = MAC;
            MAC:     if (last_tap) state_d = IDLE;
            default:               state_d = IDLE;
         endcase
      end
   end

   // output logic
   always_comb begin
      ready = 1'b0;
      if (state_q == IDLE) ready = i_en;
   end

   assign accept   = bus.i_valid & ready;
   assign last_tap = (cnt_q == LAST_TAP);
   assign coef_wr  = bus.i_coef_we & i_en & (state_q == IDLE) &
                     ({1'b0, bus.i_coef_addr} < NTAPS_W);

   assign coef_sel = coef_q[cnt_q];
   assign x_sel    = x_q[cnt_q];
   assign coef_ext = {{NB_INPUT{coef_sel[NB_COEFF-1]}}, coef_sel};
   assign x_ext    = {{NB_COEFF{x_sel[NB_INPUT-1]}}, x_sel};
   assign prod     = coef_ext * x_ext;
   assign sum      = acc_q + {{(NB_ADD-NB_PROD){prod[NB_PROD-1]}}, prod};
   assign sum_top  = sum[NB_ADD-1 -: NB_SAT+1];

   // Integer guard bits must all agree with the sign, otherwise clip.
   always_comb begin
      sat_val = sum[NB_ADD-NB_SAT-1 -: NB_OUTPUT];
      if ((sum_top != '0) && (sum_top != '1))
         sat_val = sum[NB_ADD-1] ? OUT_MIN : OUT_MAX;
   end

   always_ff @(posedge clk) begin
      if (i_srst) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         for (int k = 0; k < NSLOT; k++) begin
            x_q[k]    <= '0;
            coef_q[k] <= (k < NTAPS) ? coef_default(k) : '0;
         end
      end else if (i_en) begin
         valid_q <= 1'b0;
         if (coef_wr) coef_q[bus.i_coef_addr] <= bus.i_coef_data;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q[0] <= bus.i_is_data;
                  for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            MAC: begin
               acc_q <= sum;
               cnt_q <= cnt_q + 1'b1;
               if (last_tap) begin
                  out_q   <= sat_val;
                  valid_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_ready   = ready;
   assign bus.o_valid   = valid_q;
   assign bus.o_os_data = out_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer; expected outputs are hand-computed
// from the default coefficients -1, 1/2, -1/4, 1/8 in S(8,7).
module tb_fir_mac_sequencer;
   localparam int NB_ADDR = 3;

   logic clk = 1'b0;
   logic srst;
   logic en;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fir_mac_if #(.NB_ADDR(NB_ADDR)) bus ();

   fir_mac_sequencer #(.NB_ADDR(NB_ADDR)) dut (
      .clk    (clk),
      .i_srst (srst),
      .i_en   (en),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.o_ready && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
   endtask

   task automatic accept(input logic [7:0] x);
      bus.i_valid   = 1'b1;
      bus.i_is_data = x;
      tick();
      bus.i_valid   = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int exp_lat, input logic [7:0] exp);
      int n = 0;
      while (!bus.o_valid && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_data"}, 32'(bus.o_os_data), 32'(exp));
   endtask

   task automatic run(input string tag, input logic [7:0] x, input logic [7:0] exp);
      wait_ready(tag);
      accept(x);
      wait_out(tag, 4, exp);
   endtask

   task automatic write_coef(input logic [NB_ADDR-1:0] a, input logic [7:0] d);
      bus.i_coef_we   = 1'b1;
      bus.i_coef_addr = a;
      bus.i_coef_data = d;
      tick();
      bus.i_coef_we   = 1'b0;
   endtask

   logic [7:0] imp_in   [5] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] imp_exp  [5] = '{8'hC0, 8'h20, 8'hF0, 8'h08, 8'h00};
   logic [7:0] step_exp [5] = '{8'h7F, 8'h40, 8'h60, 8'h50, 8'h50};

   initial begin
      int n;
      bus.i_valid     = 1'b0;
      bus.i_is_data   = '0;
      bus.i_coef_we   = 1'b0;
      bus.i_coef_addr = '0;
      bus.i_coef_data = '0;
      en   = 1'b1;
      srst = 1'b1;
      tick();
      tick();
      srst = 1'b0;
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_data",  32'(bus.o_os_data), 32'd0);
      check("rst_ready", 32'(bus.o_ready), 32'd1);

      for (int i = 0; i < 5; i++) run($sformatf("imp%0d", i), imp_in[i], imp_exp[i]);
      for (int i = 0; i < 5; i++) run($sformatf("step%0d", i), 8'h80, step_exp[i]);

      // continuous i_valid: one accept and one pulse every 5 cycles
      bus.i_valid   = 1'b1;
      bus.i_is_data = 8'h00;
      for (int i = 0; i < 15; i++) begin
         check($sformatf("tim_ready%0d", i), 32'(bus.o_ready), 32'(i % 5 == 0));
         check($sformatf("tim_valid%0d", i), 32'(bus.o_valid), 32'(i % 5 == 0));
         tick();
      end
      bus.i_valid = 1'b0;

      // delay line now 0,0,0,0x80
      write_coef(0, 8'h40);
      run("cw_flush", 8'h00, 8'h00);
      run("cw_a", 8'h40, 8'h20);
      wait_ready("cw_same");
      bus.i_coef_we   = 1'b1;
      bus.i_coef_addr = 0;
      bus.i_coef_data = 8'h80;
      accept(8'h40);
      bus.i_coef_we   = 1'b0;
      wait_out("cw_same", 4, 8'hE0);

      // write during MAC is dropped; delay line 0,0x40,0x40,0
      wait_ready("mac_wr");
      accept(8'h00);
      bus.i_coef_we   = 1'b1;
      bus.i_coef_addr = 1;
      bus.i_coef_data = 8'h7F;
      tick();
      tick();
      tick();
      bus.i_coef_we   = 1'b0;
      wait_out("mac_wr", 1, 8'h10);
      run("mw1", 8'h00, 8'hF8);
      run("mw2", 8'h00, 8'h08);
      run("mw3", 8'h00, 8'h00);
      run("mw_imp", 8'h40, 8'hC0);
      run("mw_c1", 8'h00, 8'h20);

      // out-of-range addresses; delay line becomes 0x40,0,0x40,0
      write_coef(4, 8'h7F);
      write_coef(7, 8'h7F);
      run("oor", 8'h40, 8'hB0);

      // 3-cycle stall mid-MAC; delay line becomes 0,0x40,0,0x40
      wait_ready("stall");
      accept(8'h00);
      n = 0;
      while (!bus.o_valid && n < 30) begin
         if (n == 2) en = 1'b0;
         if (n == 5) en = 1'b1;
         if (!en) check($sformatf("stall_ready%0d", n), 32'(bus.o_ready), 32'd0);
         tick();
         n++;
      end
      check("stall_lat",  32'(n), 32'd7);
      check("stall_data", 32'(bus.o_os_data), 32'h28);

      en = 1'b0;
      tick();
      check("hold_valid1", 32'(bus.o_valid), 32'd1);
      tick();
      check("hold_valid2", 32'(bus.o_valid), 32'd1);
      check("hold_data",   32'(bus.o_os_data), 32'h28);
      en = 1'b1;
      tick();
      check("hold_clear", 32'(bus.o_valid), 32'd0);
      check("hold_keep",  32'(bus.o_os_data), 32'h28);
      check("hold_ready", 32'(bus.o_ready), 32'd1);

      // reset at tap 2 aborts the result and restores default coefficients
      write_coef(0, 8'h20);
      wait_ready("rstm");
      accept(8'h40);
      tick();
      tick();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      check("rstm_ready", 32'(bus.o_ready), 32'd1);
      check("rstm_valid", 32'(bus.o_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rstm_quiet%0d", i), 32'(bus.o_valid), 32'd0);
      end
      run("rstm_imp", 8'h40, 8'hC0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
